div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 31 +++
 rtl/div_ctrl.sv | 151 +++++++++++++++
 tb/tb_div_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared execute types for the divide controller
//
// Contents:
//   div_op_t     : packed divide opcode {w, rem, uns}
//   OP_*_BIT     : bit positions of the div_op_t fields inside a 3-bit opcode
//   div_state_t  : controller state encoding
//   sext32       : sign-extend a 32-bit value to 64 bits
package div_ctrl_pkg;

    typedef struct packed {
        logic w;    // 32-bit (word) operation
        logic rem;  // return remainder instead of quotient
        logic uns;  // unsigned operation
    } div_op_t;

    localparam int OP_W_BIT   = 2;
    localparam int OP_REM_BIT = 1;
    localparam int OP_UNS_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } div_state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sign/width wrapper and sequencing around an unsigned divider core
//
// Ports:
//   clk, resetn              : clock, synchronous active-low reset
//   in_valid/in_ready        : request handshake; in_op/in_a/in_b/in_tag request payload
//   flush                    : kill the in-flight operation
//   out_valid/out_ready      : result handshake; out_data/out_tag result payload
//   dv_valid/dv_a/dv_b       : request to the unsigned divider core (operand magnitudes)
//   dv_quot/dv_rem/dv_ok     : core result, dv_ok is a one-cycle pulse
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             dv_valid,
    output logic [63:0]      dv_a,
    output logic [63:0]      dv_b,
    input  logic [63:0]      dv_quot,
    input  logic [63:0]      dv_rem,
    input  logic             dv_ok
);

    div_state_t state, state_nxt;
    div_op_t    op_in;
    logic       accept;

    logic [63:0] a_ext, b_ext, a_mag, b_mag, special_res, q_fix, r_fix, core_res;
    logic        a_neg, b_neg, is_div0, is_ovf;

    // Latched per-operation controls for post-processing the core result.
    logic w_q, rem_q, neg_q, neg_r;

    assign op_in = div_op_t'(in_op);

    // Operand preparation and special-case detection on the prepared operands.
    always_comb begin
        a_ext = in_a;
        b_ext = in_b;
        if (op_in.w) begin
            a_ext = op_in.uns ? {32'd0, in_a[31:0]} : sext32(in_a[31:0]);
            b_ext = op_in.uns ? {32'd0, in_b[31:0]} : sext32(in_b[31:0]);
        end
        a_neg   = !op_in.uns && a_ext[63];
        b_neg   = !op_in.uns && b_ext[63];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        is_div0 = (b_ext == 64'd0);
        // a_ext is already sign-extended for word ops, so the most negative
        // word value appears as 0xFFFFFFFF80000000.
        is_ovf  = !op_in.uns && (b_ext == {64{1'b1}}) &&
                  (a_ext == (op_in.w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        if (is_div0)
            special_res = op_in.rem ? a_ext : {64{1'b1}};
        else
            special_res = op_in.rem ? 64'd0 : a_ext;
        if (op_in.w)
            special_res = sext32(special_res[31:0]);
    end

    // Core result post-processing: restore signs, then word-width sign extension.
    always_comb begin
        q_fix    = neg_q ? -dv_quot : dv_quot;
        r_fix    = neg_r ? -dv_rem  : dv_rem;
        core_res = rem_q ? r_fix : q_fix;
        if (w_q)
            core_res = sext32(core_res[31:0]);
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dv_valid  = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A flush in IDLE blocks the handshake rather than losing a request.
                in_ready = !flush;
                accept   = in_valid && !flush;
                if (accept)
                    state_nxt = (is_div0 || is_ovf) ? ST_DONE : ST_BUSY;
            end
            ST_BUSY: begin
                dv_valid = 1'b1;
                if (flush)
                    // If the core answers in the flush cycle there is nothing left to drain.
                    state_nxt = dv_ok ? ST_IDLE : ST_DRAIN;
                else if (dv_ok)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready)
                    state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (dv_ok)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_data <= 64'd0;
            out_tag  <= '0;
            dv_a     <= 64'd0;
            dv_b     <= 64'd0;
            w_q      <= 1'b0;
            rem_q    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            if (accept) begin
                out_tag <= in_tag;
                dv_a    <= a_mag;
                dv_b    <= b_mag;
                w_q     <= op_in.w;
                rem_q   <= op_in.rem;
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= a_neg;
                if (is_div0 || is_ovf)
                    out_data <= special_res;
            end
            if (state == ST_BUSY && dv_ok && !flush)
                out_data <= core_res;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl
module tb_div_ctrl;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             dv_valid;
    logic [63:0]      dv_a;
    logic [63:0]      dv_b;
    logic [63:0]      dv_quot;
    logic [63:0]      dv_rem;
    logic             dv_ok;

    int checks   = 0;
    int failures = 0;

    // {w, rem, uns}
    localparam logic [2:0] OP_DIV   = 3'b000;
    localparam logic [2:0] OP_REM   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_REMU  = 3'b011;
    localparam logic [2:0] OP_DIVW  = 3'b100;
    localparam logic [2:0] OP_DIVUW = 3'b101;

    always #5 clk = ~clk;

    div_ctrl #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .dv_valid  (dv_valid),
        .dv_a      (dv_a),
        .dv_b      (dv_b),
        .dv_quot   (dv_quot),
        .dv_rem    (dv_rem),
        .dv_ok     (dv_ok)
    );

    logic [63:0]      r_data;
    logic [TAG_W-1:0] r_tag;
    int               r_cyc;
    bit               r_saw_dv;
    bit               r_timeout;
    bit               r_acc_ok;

    // Issue one request, play the unsigned core (answers lat cycles into dv_valid),
    // wait for the result and consume it. Runs negedge to negedge.
    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [TAG_W-1:0] tag, input int lat);
        int dvcnt;
        @(negedge clk);
        r_acc_ok  = in_ready;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        @(negedge clk);
        in_valid  = 1'b0;
        r_cyc     = 0;
        r_saw_dv  = 1'b0;
        dvcnt     = 0;
        while (!out_valid && r_cyc < 100) begin
            if (dv_valid) begin
                r_saw_dv = 1'b1;
                dvcnt++;
                if (dvcnt == lat) begin
                    dv_ok   = 1'b1;
                    dv_quot = dv_a / dv_b;
                    dv_rem  = dv_a % dv_b;
                end
            end
            @(negedge clk);
            dv_ok = 1'b0;
            r_cyc++;
        end
        r_timeout = !out_valid;
        r_data    = out_data;
        r_tag     = out_tag;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dv_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b dv_valid=%b expected 1 0 0",
                     in_ready, out_valid, dv_valid);
        end
        checks++;
        if (out_data !== 64'd0 || out_tag !== '0 || dv_a !== 64'd0 || dv_b !== 64'd0) begin
            failures++;
            $display("FAIL reset_data: out_data=%h out_tag=%h dv_a=%h dv_b=%h expected all 0",
                     out_data, out_tag, dv_a, dv_b);
        end
    endtask

    task automatic test_signed();
        do_op(OP_DIV, -64'sd7, 64'd2, 5'd3, 3);
        checks++;
        if (r_timeout || !r_acc_ok || r_data !== 64'hFFFF_FFFF_FFFF_FFFD || r_tag !== 5'd3) begin
            failures++;
            $display("FAIL div_neg7_2: data=%h tag=%0d timeout=%b expected FFFFFFFFFFFFFFFD tag 3",
                     r_data, r_tag, r_timeout);
        end
        do_op(OP_REM, -64'sd7, 64'd2, 5'd4, 3);
        checks++;
        if (r_timeout || r_data !== 64'hFFFF_FFFF_FFFF_FFFF || r_tag !== 5'd4) begin
            failures++;
            $display("FAIL rem_neg7_2: data=%h tag=%0d expected FFFFFFFFFFFFFFFF tag 4", r_data, r_tag);
        end
    endtask

    task automatic test_div_zero();
        do_op(OP_DIVU, 64'd5, 64'd0, 5'd7, 3);
        checks++;
        if (r_timeout || r_data !== 64'hFFFF_FFFF_FFFF_FFFF || r_cyc !== 0 || r_saw_dv) begin
            failures++;
            $display("FAIL divu_by_zero: data=%h cyc=%0d saw_dv=%b expected FFFFFFFFFFFFFFFF 0 0",
                     r_data, r_cyc, r_saw_dv);
        end
        do_op(OP_REMU, 64'd5, 64'd0, 5'd8, 3);
        checks++;
        if (r_timeout || r_data !== 64'd5 || r_cyc !== 0 || r_saw_dv) begin
            failures++;
            $display("FAIL remu_by_zero: data=%h cyc=%0d saw_dv=%b expected 5 0 0",
                     r_data, r_cyc, r_saw_dv);
        end
    endtask

    task automatic test_overflow();
        do_op(OP_DIV, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd1, 3);
        checks++;
        if (r_timeout || r_data !== 64'h8000_0000_0000_0000 || r_cyc !== 0 || r_saw_dv) begin
            failures++;
            $display("FAIL div_ovf: data=%h cyc=%0d saw_dv=%b expected 8000000000000000 0 0",
                     r_data, r_cyc, r_saw_dv);
        end
        do_op(OP_REM, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd2, 3);
        checks++;
        if (r_timeout || r_data !== 64'd0 || r_saw_dv) begin
            failures++;
            $display("FAIL rem_ovf: data=%h saw_dv=%b expected 0 0", r_data, r_saw_dv);
        end
        do_op(OP_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd9, 3);
        checks++;
        if (r_timeout || r_data !== 64'hFFFF_FFFF_8000_0000 || r_saw_dv) begin
            failures++;
            $display("FAIL divw_ovf: data=%h saw_dv=%b expected FFFFFFFF80000000 0", r_data, r_saw_dv);
        end
    endtask

    task automatic test_word();
        do_op(OP_DIVW, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'd10, 2);
        checks++;
        if (r_timeout || r_data !== 64'hFFFF_FFFF_FFFF_FFFD || !r_saw_dv) begin
            failures++;
            $display("FAIL divw: data=%h saw_dv=%b expected FFFFFFFFFFFFFFFD 1", r_data, r_saw_dv);
        end
        do_op(OP_DIVUW, 64'hFFFF_FFFF_8000_0000, 64'd2, 5'd11, 4);
        checks++;
        if (r_timeout || r_data !== 64'h0000_0000_4000_0000 || r_tag !== 5'd11) begin
            failures++;
            $display("FAIL divuw: data=%h tag=%0d expected 0000000040000000 tag 11", r_data, r_tag);
        end
    endtask

    task automatic test_flush();
        bit seen_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_DIV;
        in_a     = 64'd100;
        in_b     = 64'd7;
        in_tag   = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (dv_valid !== 1'b1 || dv_a !== 64'd100 || dv_b !== 64'd7) begin
            failures++;
            $display("FAIL busy_core_req: dv_valid=%b dv_a=%h dv_b=%h expected 1 64 7", dv_valid, dv_a, dv_b);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (dv_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL drain_state: dv_valid=%b in_ready=%b expected 0 0", dv_valid, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen_valid = 1'b1;
            if (i == 9) begin
                dv_ok   = 1'b1;
                dv_quot = 64'd14;
                dv_rem  = 64'd2;
            end
            @(negedge clk);
        end
        dv_ok = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL drain_release: in_ready=%b expected 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            if (out_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen_valid) begin
            failures++;
            $display("FAIL flush_no_output: out_valid seen=%b expected 0", seen_valid);
        end
    endtask

    task automatic test_backpressure();
        int  cyc = 0;
        bit  bad = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_DIV;
        in_a     = 64'd20;
        in_b     = 64'd3;
        in_tag   = 5'd21;
        @(negedge clk);
        in_valid = 1'b0;
        dv_ok    = 1'b1;
        dv_quot  = 64'd6;
        dv_rem   = 64'd2;
        @(negedge clk);
        dv_ok = 1'b0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_data !== 64'd6 || out_tag !== 5'd21) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL hold_stable: out_valid=%b data=%h tag=%0d expected 1 6 21",
                     out_valid, out_data, out_tag);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_busy();
        bit seen_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_DIVU;
        in_a     = 64'd50;
        in_b     = 64'd5;
        in_tag   = 5'd30;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (dv_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_busy: dv_valid=%b expected 1", dv_valid);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || dv_valid !== 1'b0 || out_data !== 64'd0 || out_tag !== '0) begin
            failures++;
            $display("FAIL reset_mid_busy: in_ready=%b dv_valid=%b data=%h tag=%0d expected 1 0 0 0",
                     in_ready, dv_valid, out_data, out_tag);
        end
        @(negedge clk);
        dv_ok   = 1'b1;
        dv_quot = 64'd10;
        dv_rem  = 64'd0;
        @(negedge clk);
        dv_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen_valid || out_data !== 64'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_dv_ok: out_valid seen=%b data=%h in_ready=%b expected 0 0 1",
                     seen_valid, out_data, in_ready);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = 64'd0;
        in_b      = 64'd0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        dv_quot   = 64'd0;
        dv_rem    = 64'd0;
        dv_ok     = 1'b0;
        test_reset();
        test_signed();
        test_div_zero();
        test_overflow();
        test_word();
        test_flush();
        test_backpressure();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
